// File: rtl/aibcr3pnr_dll_lock_seq.sv
// DLL lock sequencer: reset, settle, calibrate with retries, then track lock.
// All outputs are flops updated from the next-state decision.
module aibcr3pnr_dll_lock_seq #(
    parameter int unsigned RST_CYC     = 4,
    parameter int unsigned LOCK_STABLE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dll_lock,
    input  logic [7:0]  settle_cnt,
    input  logic [11:0] lock_timeout,
    input  logic [2:0]  max_retry,
    output logic        dll_rstn_req,
    output logic        dll_cal_en,
    output logic        dll_locked,
    output logic        dll_fail,
    output logic        lock_lost,
    output logic [2:0]  retry_cnt,
    output logic [2:0]  seq_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST    = 3'd1,
        SETTLE = 3'd2,
        CAL    = 3'd3,
        LOCKED = 3'd4,
        FAIL   = 3'd5
    } state_e;

    localparam logic [12:0] RST_LAST = 13'(RST_CYC - 1);
    localparam logic [3:0]  STABLE   = 4'(LOCK_STABLE);

    state_e      state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic [3:0]  stab_q, stab_d;
    logic [2:0]  retry_q, retry_d;
    logic        lost_d;

    logic [12:0] tmo_lim;
    logic [12:0] settle_last;
    logic [12:0] cnt_inc;
    logic [3:0]  stab_inc;
    logic [3:0]  drop_inc;

    always_comb begin
        // lock_timeout of zero stands for the full 4096-cycle window
        tmo_lim     = (lock_timeout == 12'd0) ? 13'd4096 : {1'b0, lock_timeout};
        settle_last = (settle_cnt == 8'd0) ? 13'd0
                                           : {5'd0, settle_cnt} - 13'd1;
        cnt_inc     = cnt_q + 13'd1;
        stab_inc    = dll_lock ? stab_q + 4'd1 : 4'd0;
        drop_inc    = dll_lock ? 4'd0 : stab_q + 4'd1;

        state_d = state_q;
        cnt_d   = cnt_q;
        stab_d  = stab_q;
        retry_d = retry_q;
        lost_d  = 1'b0;

        if (!start) begin
            state_d = IDLE;
            cnt_d   = '0;
            stab_d  = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RST;
                    cnt_d   = '0;
                    stab_d  = '0;
                    retry_d = '0;
                end
                RST: begin
                    if (cnt_q >= RST_LAST) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                SETTLE: begin
                    if (cnt_q >= settle_last) begin
                        state_d = CAL;
                        cnt_d   = '0;
                        stab_d  = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                CAL: begin
                    cnt_d  = cnt_inc;
                    stab_d = stab_inc;
                    // Lock qualification beats a simultaneous timeout
                    if (stab_inc >= STABLE) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                        stab_d  = '0;
                    end else if (cnt_inc >= tmo_lim) begin
                        cnt_d  = '0;
                        stab_d = '0;
                        if (retry_q < max_retry) begin
                            state_d = RST;
                            retry_d = (retry_q == 3'd7) ? 3'd7 : retry_q + 3'd1;
                        end else begin
                            state_d = FAIL;
                        end
                    end
                end
                LOCKED: begin
                    stab_d = drop_inc;
                    if (drop_inc >= STABLE) begin
                        state_d = RST;
                        lost_d  = 1'b1;
                        retry_d = '0;
                        stab_d  = '0;
                        cnt_d   = '0;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    stab_d  = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            stab_q       <= '0;
            retry_q      <= '0;
            dll_rstn_req <= 1'b0;
            dll_cal_en   <= 1'b0;
            dll_locked   <= 1'b0;
            dll_fail     <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stab_q       <= stab_d;
            retry_q      <= retry_d;
            dll_rstn_req <= (state_d == SETTLE) || (state_d == CAL) ||
                            (state_d == LOCKED);
            dll_cal_en   <= (state_d == CAL) || (state_d == LOCKED);
            dll_locked   <= (state_d == LOCKED);
            dll_fail     <= (state_d == FAIL);
            lock_lost    <= lost_d;
        end
    end

    assign retry_cnt = retry_q;
    assign seq_state = state_q;

endmodule

// File: tb/tb_aibcr3pnr_dll_lock_seq.sv
// Directed bench for the DLL lock sequencer with hand-derived cycle counts.
module tb_aibcr3pnr_dll_lock_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dll_lock;
    logic [7:0]  settle_cnt;
    logic [11:0] lock_timeout;
    logic [2:0]  max_retry;
    logic        dll_rstn_req;
    logic        dll_cal_en;
    logic        dll_locked;
    logic        dll_fail;
    logic        lock_lost;
    logic [2:0]  retry_cnt;
    logic [2:0]  seq_state;

    int n_chk = 0;
    int n_err = 0;

    aibcr3pnr_dll_lock_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dll_lock     (dll_lock),
        .settle_cnt   (settle_cnt),
        .lock_timeout (lock_timeout),
        .max_retry    (max_retry),
        .dll_rstn_req (dll_rstn_req),
        .dll_cal_en   (dll_cal_en),
        .dll_locked   (dll_locked),
        .dll_fail     (dll_fail),
        .lock_lost    (lock_lost),
        .retry_cnt    (retry_cnt),
        .seq_state    (seq_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n;
        n = 0;
        while (seq_state !== s && n < budget) begin
            tick();
            n++;
        end
        chk("wait_state", {13'd0, seq_state}, {13'd0, s});
    endtask

    task automatic cal_len(output int n);
        n = 1;
        tick();
        while (seq_state == 3'd3 && n < 5000) begin
            n++;
            tick();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"},
            {10'd0, dll_rstn_req, dll_cal_en, dll_locked, dll_fail,
             lock_lost, 1'b0},
            16'd0);
        chk({tag, "_state"}, {13'd0, seq_state}, 16'd0);
        chk({tag, "_retry"}, {13'd0, retry_cnt}, 16'd0);
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        start        = 1'b0;
        dll_lock     = 1'b0;
        settle_cnt   = 8'd10;
        lock_timeout = 12'd100;
        max_retry    = 3'd2;
        #3;
        chk_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();
        chk("idle_hold", {13'd0, seq_state}, 16'd0);

        // Nominal lock
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("nom_rst", {12'd0, seq_state, dll_rstn_req}, {12'd0, 3'd1, 1'b0});
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("nom_settle", {12'd0, seq_state, dll_rstn_req},
                {12'd0, 3'd2, 1'b1});
        end
        dll_lock = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("nom_cal", {11'd0, seq_state, dll_cal_en, dll_locked},
                {11'd0, 3'd3, 1'b1, 1'b0});
        end
        tick();
        chk("nom_locked", {10'd0, seq_state, dll_locked, dll_cal_en, dll_rstn_req},
            {10'd0, 3'd4, 1'b1, 1'b1, 1'b1});
        chk("nom_retry", {13'd0, retry_cnt}, 16'd0);

        // Short drop ignored
        dll_lock = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("glitch7", {12'd0, seq_state, lock_lost}, {12'd0, 3'd4, 1'b0});
        end
        dll_lock = 1'b1;
        tick();
        chk("glitch7_end", {12'd0, seq_state, lock_lost}, {12'd0, 3'd4, 1'b0});

        // Eight-cycle drop loses lock
        dll_lock = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("drop8_hold", {12'd0, seq_state, lock_lost}, {12'd0, 3'd4, 1'b0});
        end
        tick();
        chk("drop8_lost", {11'd0, seq_state, lock_lost, dll_locked},
            {11'd0, 3'd1, 1'b1, 1'b0});
        tick();
        chk("drop8_pulse", {12'd0, seq_state, lock_lost}, {12'd0, 3'd1, 1'b0});

        // Async reset while LOCKED
        dll_lock = 1'b1;
        wait_state(3'd4, 60);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        #2;
        rst = 1'b0;
        tick();
        chk("rst_restart", {10'd0, seq_state, retry_cnt}, {10'd0, 3'd1, 3'd0});

        // Retry then fail
        start = 1'b0;
        tick();
        chk_all_zero("stop1");
        lock_timeout = 12'd20;
        max_retry    = 3'd2;
        dll_lock     = 1'b0;
        start        = 1'b1;
        for (int a = 0; a < 3; a++) begin
            wait_state(3'd3, 40);
            cal_len(n);
            chk("retry_cal_len", 16'(n), 16'd20);
            if (a < 2) begin
                chk("retry_rst", {10'd0, seq_state, retry_cnt},
                    {10'd0, 3'd1, 3'(a + 1)});
            end
        end
        chk("fail_state", {10'd0, seq_state, retry_cnt}, {10'd0, 3'd5, 3'd2});
        chk("fail_outs", {13'd0, dll_fail, dll_rstn_req, dll_cal_en},
            {13'd0, 1'b1, 1'b0, 1'b0});
        tick();
        tick();
        chk("fail_sticky", {12'd0, seq_state, dll_fail}, {12'd0, 3'd5, 1'b1});
        start = 1'b0;
        tick();
        chk_all_zero("fail_exit");

        // settle_cnt=0, lock and timeout coincide at 8
        settle_cnt   = 8'd0;
        lock_timeout = 12'd8;
        dll_lock     = 1'b1;
        start        = 1'b1;
        wait_state(3'd2, 20);
        tick();
        chk("settle0_one", {13'd0, seq_state}, 16'd3);
        cal_len(n);
        chk("bnd_cal_len", 16'(n), 16'd8);
        chk("bnd_locked", {10'd0, seq_state, retry_cnt}, {10'd0, 3'd4, 3'd0});

        // Abort from CAL via start=0
        start = 1'b0;
        tick();
        settle_cnt   = 8'd3;
        lock_timeout = 12'd100;
        dll_lock     = 1'b0;
        start        = 1'b1;
        wait_state(3'd3, 20);
        tick();
        tick();
        start = 1'b0;
        tick();
        chk_all_zero("abort_cal");
        start = 1'b1;
        tick();
        chk("abort_restart", {10'd0, seq_state, retry_cnt}, {10'd0, 3'd1, 3'd0});

        // Toggling lock never qualifies; timeout with no retries fails
        start = 1'b0;
        tick();
        lock_timeout = 12'd20;
        max_retry    = 3'd0;
        start        = 1'b1;
        wait_state(3'd3, 20);
        n = 0;
        while (seq_state == 3'd3 && n < 100) begin
            dll_lock = ((n / 3) % 2) == 0;
            tick();
            n++;
        end
        chk("toggle_cal_len", 16'(n), 16'd20);
        chk("toggle_fail", {9'd0, seq_state, retry_cnt, dll_fail},
            {9'd0, 3'd5, 3'd0, 1'b1});

        start = 1'b0;
        tick();
        chk("final_idle", {13'd0, seq_state}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
